// File: rtl/opp_state_rx.sv
// opp_state_rx: per-opponent state demux with sequence filter, staleness
// timeout and confirmed remote reset. Option macro: OPP_STATE_RX_STATS_EN.
module opp_state_rx #(
   parameter int NUM_OPP     = 2,
   parameter int ID_W        = 2,
   parameter int POS_W       = 11,
   parameter int DIR_W       = 9,
   parameter int TIMEOUT     = 2500000,
   parameter int RST_CONFIRM = 3,
   localparam int PKT_W      = 2*POS_W+DIR_W+8+ID_W
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     axiiv,
   input  logic [PKT_W-1:0]         axiid,
   output logic [NUM_OPP*POS_W-1:0] opp_x_out,
   output logic [NUM_OPP*POS_W-1:0] opp_y_out,
   output logic [NUM_OPP*DIR_W-1:0] opp_dir_out,
   output logic [NUM_OPP*3-1:0]     opp_game_out,
   output logic [NUM_OPP-1:0]       opp_valid_out,
   output logic [NUM_OPP-1:0]       update_out,
   output logic [NUM_OPP-1:0]       stale_out,
   output logic                     opp_reset_out,
   output logic [ID_W-1:0]          reset_src_out
`ifdef OPP_STATE_RX_STATS_EN
   ,
   output logic [15:0]              rx_ok_count_out,
   output logic [15:0]              rx_drop_count_out,
   output logic [15:0]              rx_stale_count_out
`endif
);

   localparam int TC_W = $clog2(TIMEOUT+1);
   localparam int RC_W = $clog2(RST_CONFIRM+1);
   localparam logic [TC_W-1:0] T_LAST  = TC_W'(TIMEOUT-1);
   localparam logic [TC_W-1:0] T_SAT   = TC_W'(TIMEOUT);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CONFIRM-1);
   localparam logic [ID_W:0]   N_OPP   = (ID_W+1)'(NUM_OPP);

   logic             pkt_v;
   logic [PKT_W-1:0] pkt_d;
   logic [POS_W-1:0] px, py;
   logic [DIR_W-1:0] pdir;
   logic [2:0]       pgame;
   logic             prr;
   logic [3:0]       pseq;
   logic [ID_W-1:0]  pid;

   assign {px, py, pdir, pgame, prr, pseq, pid} = pkt_d;

   logic [3:0]      last_seq [NUM_OPP];
   logic [TC_W-1:0] tcnt     [NUM_OPP];
   logic [RC_W-1:0] rcnt     [NUM_OPP];

   logic [3:0]         cur_seq, dseq;
   logic               cur_vld, id_ok, seq_ok, acc;
   logic [NUM_OPP-1:0] hit, tmo;

   // Window of 1..8 ahead of last_seq tolerates loss but rejects replays.
   always_comb begin
      cur_seq = '0;
      cur_vld = 1'b0;
      hit     = '0;
      tmo     = '0;
      for (int k = 0; k < NUM_OPP; k++) begin
         if (pid == ID_W'(k)) begin
            cur_seq = last_seq[k];
            cur_vld = opp_valid_out[k];
         end
      end
      id_ok  = {1'b0, pid} < N_OPP;
      dseq   = pseq - cur_seq;
      seq_ok = !cur_vld || (dseq != 4'd0 && dseq <= 4'd8);
      acc    = pkt_v && (|pkt_d) && id_ok && seq_ok;
      for (int k = 0; k < NUM_OPP; k++) begin
         hit[k] = acc && (pid == ID_W'(k));
         tmo[k] = opp_valid_out[k] && !hit[k] && (tcnt[k] == T_LAST);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         pkt_v         <= 1'b0;
         pkt_d         <= '0;
         opp_x_out     <= '0;
         opp_y_out     <= '0;
         opp_dir_out   <= '0;
         opp_game_out  <= '0;
         opp_valid_out <= '0;
         update_out    <= '0;
         stale_out     <= '0;
         opp_reset_out <= 1'b0;
         reset_src_out <= '0;
         for (int k = 0; k < NUM_OPP; k++) begin
            last_seq[k] <= '0;
            tcnt[k]     <= '0;
            rcnt[k]     <= '0;
         end
      end else begin
         pkt_v         <= axiiv;
         pkt_d         <= axiid;
         update_out    <= hit;
         stale_out     <= tmo;
         opp_reset_out <= 1'b0;
         for (int k = 0; k < NUM_OPP; k++) begin
            if (hit[k]) begin
               opp_x_out[k*POS_W +: POS_W]   <= px;
               opp_y_out[k*POS_W +: POS_W]   <= py;
               opp_dir_out[k*DIR_W +: DIR_W] <= pdir;
               opp_game_out[k*3 +: 3]        <= pgame;
               last_seq[k]      <= pseq;
               opp_valid_out[k] <= 1'b1;
               tcnt[k]          <= '0;
               if (!prr) begin
                  rcnt[k] <= '0;
               end else if (rcnt[k] == RC_LAST) begin
                  rcnt[k]       <= '0;
                  opp_reset_out <= 1'b1;
                  reset_src_out <= pid;
               end else begin
                  rcnt[k] <= rcnt[k] + RC_W'(1);
               end
            end else if (tmo[k]) begin
               opp_valid_out[k] <= 1'b0;
               tcnt[k]          <= T_SAT;
            end else if (opp_valid_out[k]) begin
               tcnt[k] <= tcnt[k] + TC_W'(1);
            end
         end
      end
   end

`ifdef OPP_STATE_RX_STATS_EN
   logic          drop;
   logic [ID_W:0] n_tmo;

   function automatic logic [15:0] sat_add(input logic [15:0] a,
                                           input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   always_comb begin
      drop  = pkt_v && !acc;
      n_tmo = '0;
      for (int k = 0; k < NUM_OPP; k++) begin
         n_tmo = n_tmo + (ID_W+1)'(tmo[k]);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rx_ok_count_out    <= '0;
         rx_drop_count_out  <= '0;
         rx_stale_count_out <= '0;
      end else begin
         rx_ok_count_out    <= sat_add(rx_ok_count_out, {15'd0, acc});
         rx_drop_count_out  <= sat_add(rx_drop_count_out, {15'd0, drop});
         rx_stale_count_out <= sat_add(rx_stale_count_out, 16'(n_tmo));
      end
   end
`endif

endmodule

// File: tb/tb_opp_state_rx.sv
// Scoreboard bench for opp_state_rx: stimulus queues expected events,
// a negedge monitor pops and compares each update/stale/reset event.
module tb_opp_state_rx;

   localparam int NUM_OPP     = 2;
   localparam int ID_W        = 2;
   localparam int POS_W       = 11;
   localparam int DIR_W       = 9;
   localparam int TIMEOUT     = 20;
   localparam int RST_CONFIRM = 3;
   localparam int PKT_W       = 2*POS_W+DIR_W+8+ID_W;

   logic                     clk_in = 1'b0;
   logic                     rst_in = 1'b0;
   logic                     axiiv  = 1'b0;
   logic [PKT_W-1:0]         axiid  = '0;
   logic [NUM_OPP*POS_W-1:0] opp_x_out, opp_y_out;
   logic [NUM_OPP*DIR_W-1:0] opp_dir_out;
   logic [NUM_OPP*3-1:0]     opp_game_out;
   logic [NUM_OPP-1:0]       opp_valid_out, update_out, stale_out;
   logic                     opp_reset_out;
   logic [ID_W-1:0]          reset_src_out;
`ifdef OPP_STATE_RX_STATS_EN
   logic [15:0] rx_ok_count_out, rx_drop_count_out, rx_stale_count_out;
`endif

   opp_state_rx #(
      .NUM_OPP(NUM_OPP), .ID_W(ID_W), .POS_W(POS_W), .DIR_W(DIR_W),
      .TIMEOUT(TIMEOUT), .RST_CONFIRM(RST_CONFIRM)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .axiiv(axiiv), .axiid(axiid),
      .opp_x_out(opp_x_out), .opp_y_out(opp_y_out),
      .opp_dir_out(opp_dir_out), .opp_game_out(opp_game_out),
      .opp_valid_out(opp_valid_out), .update_out(update_out),
      .stale_out(stale_out), .opp_reset_out(opp_reset_out),
      .reset_src_out(reset_src_out)
`ifdef OPP_STATE_RX_STATS_EN
      , .rx_ok_count_out(rx_ok_count_out),
      .rx_drop_count_out(rx_drop_count_out),
      .rx_stale_count_out(rx_stale_count_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc++;

   typedef struct {
      int              cyc;
      int              ch;
      int              x, y, dir, game;
      logic [1:0]      upd, stl, vld;
      logic            orst;
      logic [ID_W-1:0] src;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0]      mv = '0;
   logic [ID_W-1:0] msrc = '0;
   int mx[NUM_OPP], my[NUM_OPP], md[NUM_OPP], mg[NUM_OPP];
   int last_acc[NUM_OPP];

   function automatic void chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, req, cyc);
      end
   endfunction

   function automatic logic [PKT_W-1:0] pk(input int id, sq, x, y, d, g, rr);
      return {POS_W'(x), POS_W'(y), DIR_W'(d), 3'(g), 1'(rr), 4'(sq), ID_W'(id)};
   endfunction

   task automatic send(input int id, sq, x, y, d, g, rr, acc, orst);
      exp_t e;
      axiiv = 1'b1;
      axiid = pk(id, sq, x, y, d, g, rr);
      if (acc != 0) begin
         mv[id] = 1'b1;
         mx[id] = x; my[id] = y; md[id] = d; mg[id] = g;
         if (orst != 0) msrc = ID_W'(id);
         e.cyc = cyc + 2; e.ch = id;
         e.x = x; e.y = y; e.dir = d; e.game = g;
         e.upd = 2'(1 << id); e.stl = '0; e.vld = mv;
         e.orst = (orst != 0); e.src = msrc;
         sb.push_back(e);
         last_acc[id] = cyc + 2;
      end
      @(negedge clk_in);
   endtask

   task automatic send_raw(input logic [PKT_W-1:0] w);
      axiiv = 1'b1;
      axiid = w;
      @(negedge clk_in);
   endtask

   task automatic idle_until(input int t);
      axiiv = 1'b0;
      axiid = '0;
      while (cyc < t) @(negedge clk_in);
   endtask

   task automatic wait_stale(input int ch);
      exp_t e;
      mv[ch] = 1'b0;
      e.cyc = last_acc[ch] + TIMEOUT; e.ch = ch;
      e.x = mx[ch]; e.y = my[ch]; e.dir = md[ch]; e.game = mg[ch];
      e.upd = '0; e.stl = 2'(1 << ch); e.vld = mv;
      e.orst = 1'b0; e.src = msrc;
      sb.push_back(e);
      idle_until(e.cyc + 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"}, int'(opp_x_out), 0);
      chk({tag, "_y"}, int'(opp_y_out), 0);
      chk({tag, "_dir"}, int'(opp_dir_out), 0);
      chk({tag, "_game"}, int'(opp_game_out), 0);
      chk({tag, "_valid"}, int'(opp_valid_out), 0);
      chk({tag, "_update"}, int'(update_out), 0);
      chk({tag, "_stale"}, int'(stale_out), 0);
      chk({tag, "_oreset"}, int'(opp_reset_out), 0);
      chk({tag, "_src"}, int'(reset_src_out), 0);
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if ((|update_out) || (|stale_out) || opp_reset_out) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: cyc %0d upd=%b stale=%b rst=%b, expected no event",
                     cyc, update_out, stale_out, opp_reset_out);
         end else begin
            e = sb.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_update", int'(update_out), int'(e.upd));
            chk("ev_stale", int'(stale_out), int'(e.stl));
            chk("ev_valid", int'(opp_valid_out), int'(e.vld));
            chk("ev_oreset", int'(opp_reset_out), int'(e.orst));
            chk("ev_src", int'(reset_src_out), int'(e.src));
            chk("ev_x", int'(opp_x_out[e.ch*POS_W +: POS_W]), e.x);
            chk("ev_y", int'(opp_y_out[e.ch*POS_W +: POS_W]), e.y);
            chk("ev_dir", int'(opp_dir_out[e.ch*DIR_W +: DIR_W]), e.dir);
            chk("ev_game", int'(opp_game_out[e.ch*3 +: 3]), e.game);
         end
      end
   end

   initial begin
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      chk_all_zero("reset");
      rst_in = 1'b1;

      send(1, 5, 320, 200, 90, 3, 0, 1, 0);
      send(1, 5, 1, 1, 1, 1, 0, 0, 0);
      send(1, 2, 2, 2, 2, 2, 0, 0, 0);
      send(1, 6, 400, 210, 180, 2, 0, 1, 0);
      send(1, 15, 7, 7, 7, 7, 0, 0, 0);
      send(1, 14, 500, 100, 359, 1, 0, 1, 0);
      send(2, 7, 9, 9, 9, 5, 0, 0, 0);
      send_raw('0);
      idle_until(cyc + 3);
      chk("hold_x1", int'(opp_x_out[POS_W +: POS_W]), 500);
      chk("hold_y1", int'(opp_y_out[POS_W +: POS_W]), 100);
      chk("hold_valid", int'(opp_valid_out), 2);
`ifdef OPP_STATE_RX_STATS_EN
      chk("stat_ok", int'(rx_ok_count_out), 3);
      chk("stat_drop", int'(rx_drop_count_out), 5);
`endif
      wait_stale(1);

      send(0, 3, 100, 50, 10, 2, 0, 1, 0);
      wait_stale(0);
      send(0, 3, 110, 60, 20, 4, 0, 1, 0);
      idle_until(last_acc[0] + TIMEOUT - 2);
      send(0, 4, 120, 70, 30, 5, 0, 1, 0);
      wait_stale(0);
`ifdef OPP_STATE_RX_STATS_EN
      chk("stat_stale", int'(rx_stale_count_out), 3);
`endif

      send(0, 1, 10, 10, 10, 1, 1, 1, 0);
      send(0, 2, 11, 11, 11, 1, 1, 1, 0);
      send(0, 3, 12, 12, 12, 1, 0, 1, 0);
      send(0, 4, 13, 13, 13, 1, 1, 1, 0);
      send(0, 4, 99, 99, 99, 7, 1, 0, 0);
      send(0, 5, 14, 14, 14, 1, 1, 1, 0);
      send(0, 6, 15, 15, 15, 1, 1, 1, 1);
      send(0, 7, 16, 16, 16, 1, 1, 1, 0);
      send(1, 0, 200, 201, 202, 6, 1, 1, 0);
      send(1, 1, 210, 211, 212, 6, 1, 1, 0);
      send(1, 2, 220, 221, 222, 6, 1, 1, 1);
      wait_stale(0);
      wait_stale(1);

      send(0, 9, 300, 301, 302, 3, 0, 1, 0);
      idle_until(cyc + 3);
      rst_in = 1'b0;
      axiiv  = 1'b1;
      axiid  = pk(1, 3, 77, 78, 79, 2, 1);
      @(negedge clk_in);
      chk_all_zero("midrst");
      rst_in = 1'b1;
      mv = '0;
      msrc = '0;
      idle_until(cyc + 5);
      send(1, 3, 42, 43, 44, 2, 0, 1, 0);
      wait_stale(1);

      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk_in);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_event: upd=%b stale=%b expected at cyc %0d, not observed",
                  e.upd, e.stl, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
